tx_vthernet_mac: RTL and testbench

//  GMII transmit MAC, the counterpart of the RX MAC. On a start command it reads
//  a frame (dest MAC .. payload) from the TX byte buffer and emits it on GMII:

---
 rtl/tx_vthernet_mac.sv | 271 +++++++++++++++++++++++++++
 tb/tb_tx_vthernet_mac.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tx_vthernet_mac.sv
// -----------------------------------------------------------------------------
// tx_vthernet_mac -- GMII transmit MAC.
//
// On an accepted start command the MAC streams one frame onto GMII. The frame
// is the preamble (0x55 x PRE_LEN), the SFD (0xD5), tx_len bytes read from the
// TX byte buffer, zero padding up to MIN_FRAME bytes, and the CRC-32 FCS sent
// least significant byte first. The inter-frame gap follows, and then a
// one-cycle completion interrupt. Everything runs on wb_clk_i (125 MHz).
//
// Ports
//   wb_clk_i     in   clock
//   wb_rst_i     in   synchronous active-high reset
//   tx_start     in   start request, looked at only while idle
//   tx_len       in   frame byte count (excl. FCS), captured with tx_start
//   tx_busy      out  frame in progress, from accept to the end of the IFG
//   tx_irq       out  one-cycle pulse after the last IFG cycle
//   tx_err       out  one-cycle pulse when a start is rejected (bad length)
//   tx_mem_rd    out  buffer read enable
//   tx_mem_addr  out  buffer read address
//   tx_mem_dout  in   buffer read data, valid one cycle after tx_mem_rd
//   TX_EN        out  GMII transmit enable
//   TXD          out  GMII transmit data
//   TX_ER        out  GMII transmit error, tied low
// -----------------------------------------------------------------------------
module tx_vthernet_mac #(
    parameter int ADDR_W    = 11,
    parameter int MAX_LEN   = 1514,
    parameter int MIN_FRAME = 60,
    parameter int PRE_LEN   = 7,
    parameter int IFG_BYTES = 12
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              tx_start,
    input  logic [ADDR_W-1:0] tx_len,
    output logic              tx_busy,
    output logic              tx_irq,
    output logic              tx_err,
    output logic              tx_mem_rd,
    output logic [ADDR_W-1:0] tx_mem_addr,
    input  logic [7:0]        tx_mem_dout,
    output logic              TX_EN,
    output logic [7:0]        TXD,
    output logic              TX_ER
);

    // Byte counter is one bit wider than the address so it never wraps.
    localparam int CW = ADDR_W + 1;

    localparam logic [CW-1:0] PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0] PAD_LAST  = CW'(MIN_FRAME - 1);
    localparam logic [CW-1:0] IFG_LAST  = CW'(IFG_BYTES - 1);
    localparam logic [CW-1:0] FCS_LAST  = CW'(3);
    localparam logic [CW-1:0] MAX_LEN_C = CW'(MAX_LEN);
    localparam logic [CW-1:0] MIN_FR_C  = CW'(MIN_FRAME);
    localparam logic [31:0]   CRC_POLY  = 32'hEDB8_8320;

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREAMBLE,
        S_SFD,
        S_DATA,
        S_PAD,
        S_FCS,
        S_IFG
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [ADDR_W-1:0]   len_q, len_d;
    logic [31:0]         crc_q, crc_d;
    logic                tx_en_q, tx_en_d;
    logic [7:0]          txd_q, txd_d;
    logic                busy_q, busy_d;
    logic                irq_q, irq_d;
    logic                err_q, err_d;
    logic                rd_q, rd_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;

    logic [CW-1:0]       len_ext;
    logic [CW-1:0]       next_rd_idx;
    logic [31:0]         fcs;

    // One byte of the reflected CRC-32 update, LSB first.
    function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [7:0] b);
        logic [31:0] r;
        r = c ^ {24'h0, b};
        for (int k = 0; k < 8; k++) begin
            r = r[0] ? ((r >> 1) ^ CRC_POLY) : (r >> 1);
        end
        return r;
    endfunction

    assign len_ext     = {1'b0, len_q};
    assign next_rd_idx = {1'b0, addr_q} + CW'(1);
    assign fcs         = ~crc_q;

    always_comb begin
        // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
        state_d = state_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        err_d   = 1'b0;

        // Next-state logic. cnt runs through DATA and on into PAD so the pad
        // ends when the combined byte count reaches MIN_FRAME.
        unique case (state_q)
            S_IDLE: begin
                if (tx_start) begin
                    if ((tx_len != '0) && ({1'b0, tx_len} <= MAX_LEN_C)) begin
                        state_d = S_PREAMBLE;
                        cnt_d   = '0;
                        len_d   = tx_len;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_PREAMBLE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_SFD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_SFD: begin
                state_d = S_DATA;
                cnt_d   = '0;
            end
            S_DATA: begin
                if (cnt_q == len_ext - CW'(1)) begin
                    if (len_ext < MIN_FR_C) begin
                        state_d = S_PAD;
                        cnt_d   = cnt_q + CW'(1);
                    end else begin
                        state_d = S_FCS;
                        cnt_d   = '0;
                    end
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_PAD: begin
                if (cnt_q == PAD_LAST) begin
                    state_d = S_FCS;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_FCS: begin
                if (cnt_q == FCS_LAST) begin
                    state_d = S_IFG;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_IFG: begin
                if (cnt_q == IFG_LAST) begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase

        // Outputs are registered, so they are decoded from the state being
        // entered: the wire shows exactly what the next state stands for.
        tx_en_d = 1'b0;
        txd_d   = 8'h00;
        crc_d   = crc_q;
        unique case (state_d)
            S_PREAMBLE: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h55;
                crc_d   = 32'hFFFF_FFFF;
            end
            S_SFD: begin
                tx_en_d = 1'b1;
                txd_d   = 8'hD5;
            end
            S_DATA: begin
                tx_en_d = 1'b1;
                txd_d   = tx_mem_dout;
                crc_d   = crc_step(crc_q, tx_mem_dout);
            end
            S_PAD: begin
                tx_en_d = 1'b1;
                txd_d   = 8'h00;
                crc_d   = crc_step(crc_q, 8'h00);
            end
            S_FCS: begin
                tx_en_d = 1'b1;
                unique case (cnt_d[1:0])
                    2'd0:    txd_d = fcs[7:0];
                    2'd1:    txd_d = fcs[15:8];
                    2'd2:    txd_d = fcs[23:16];
                    default: txd_d = fcs[31:24];
                endcase
            end
            default: begin
                tx_en_d = 1'b0;
                txd_d   = 8'h00;
            end
        endcase

        busy_d = (state_d != S_IDLE);
        irq_d  = (state_q == S_IFG) && (state_d == S_IDLE);

        // Buffer reads run one per cycle, len reads in total, starting in the
        // last preamble cycle. With the one-cycle buffer latency and the output
        // register each byte reaches TXD two cycles after its read.
        rd_d   = 1'b0;
        addr_d = addr_q;
        if (rd_q && (next_rd_idx < len_ext)) begin
            rd_d   = 1'b1;
            addr_d = addr_q + ADDR_W'(1);
        end else if ((state_d == S_PREAMBLE) && (cnt_d == PRE_LAST)) begin
            rd_d   = 1'b1;
            addr_d = '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge wb_clk_i) begin
        // NOTE: reset is synchronous and clears every flop, so a reset mid-frame
        // drops TX_EN on the same edge and no stale read or interrupt survives.
        if (wb_rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            len_q   <= '0;
            crc_q   <= 32'hFFFF_FFFF;
            tx_en_q <= 1'b0;
            txd_q   <= 8'h00;
            busy_q  <= 1'b0;
            irq_q   <= 1'b0;
            err_q   <= 1'b0;
            rd_q    <= 1'b0;
            addr_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
            crc_q   <= crc_d;
            tx_en_q <= tx_en_d;
            txd_q   <= txd_d;
            busy_q  <= busy_d;
            irq_q   <= irq_d;
            err_q   <= err_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
        end
    end

    assign TX_EN       = tx_en_q;
    assign TXD         = txd_q;
    assign TX_ER       = 1'b0;
    assign tx_busy     = busy_q;
    assign tx_irq      = irq_q;
    assign tx_err      = err_q;
    assign tx_mem_rd   = rd_q;
    assign tx_mem_addr = addr_q;

endmodule

// File: tb/tb_tx_vthernet_mac.sv
// -----------------------------------------------------------------------------
// tb_tx_vthernet_mac -- self-checking bench for tx_vthernet_mac.
//
// Two instances share the clock and reset: dut_a with default parameters and
// dut_b with padding disabled. Each has a one-cycle-latency buffer model. The
// GMII and control outputs are logged every cycle on the falling edge; after
// each frame the log is compared with a frame built from the rules (preamble,
// SFD, data, pad, table-driven CRC-32, IFG, interrupt).
// -----------------------------------------------------------------------------
module tb_tx_vthernet_mac;

    localparam int ADDR_W  = 11;
    localparam int MAX_LEN = 1514;
    localparam int PRE_LEN = 7;
    localparam int IFG     = 12;
    localparam int MIN_A   = 60;
    localparam int MIN_B   = 0;
    localparam int LOG_N   = 16384;

    logic              clk = 1'b0;
    logic              rst;
    logic              start_a, start_b;
    logic [ADDR_W-1:0] len_a, len_b;
    logic              busy_a, irq_a, err_a, rd_a, en_a, er_a;
    logic              busy_b, irq_b, err_b, rd_b, en_b, er_b;
    logic [ADDR_W-1:0] addr_a, addr_b;
    logic [7:0]        dout_a, dout_b, txd_a, txd_b;

    logic [7:0] mem_a [2048];
    logic [7:0] mem_b [2048];

    typedef struct packed {
        logic              er;
        logic              en;
        logic              busy;
        logic              irq;
        logic              err;
        logic              rd;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        txd;
    } samp_t;

    samp_t log_a [LOG_N];
    samp_t log_b [LOG_N];
    int    cyc = 0;

    int compared   = 0;
    int mismatched = 0;

    logic [31:0] crc_tab [256];

    always #4 clk = ~clk;

    tx_vthernet_mac #(.MIN_FRAME(MIN_A)) dut_a (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_start(start_a), .tx_len(len_a),
        .tx_busy(busy_a), .tx_irq(irq_a), .tx_err(err_a), .tx_mem_rd(rd_a),
        .tx_mem_addr(addr_a), .tx_mem_dout(dout_a), .TX_EN(en_a), .TXD(txd_a),
        .TX_ER(er_a)
    );

    tx_vthernet_mac #(.MIN_FRAME(MIN_B)) dut_b (
        .wb_clk_i(clk), .wb_rst_i(rst), .tx_start(start_b), .tx_len(len_b),
        .tx_busy(busy_b), .tx_irq(irq_b), .tx_err(err_b), .tx_mem_rd(rd_b),
        .tx_mem_addr(addr_b), .tx_mem_dout(dout_b), .TX_EN(en_b), .TXD(txd_b),
        .TX_ER(er_b)
    );

    // Buffer model: data appears one cycle after the read request.
    always @(posedge clk) begin
        if (rd_a) dout_a <= mem_a[addr_a];
        if (rd_b) dout_b <= mem_b[addr_b];
    end

    always @(negedge clk) begin
        if (cyc < LOG_N) begin
            log_a[cyc] <= {er_a, en_a, busy_a, irq_a, err_a, rd_a, addr_a, txd_a};
            log_b[cyc] <= {er_b, en_b, busy_b, irq_b, err_b, rd_b, addr_b, txd_b};
        end
        cyc <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until_cyc(input int c);
        for (int i = 0; i < LOG_N && cyc < c; i++) tick();
    endtask

    function automatic samp_t get(input bit b, input int idx);
        if (idx < 0 || idx >= LOG_N) return 'x;
        return b ? log_b[idx] : log_a[idx];
    endfunction

    task automatic start_frame(input bit b, input int len, output int acc);
        if (b) begin start_b = 1'b1; len_b = ADDR_W'(len); end
        else   begin start_a = 1'b1; len_a = ADDR_W'(len); end
        acc = cyc;
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic fill_random(input bit b, input int len);
        for (int i = 0; i < len; i++) begin
            if (b) mem_b[i] = 8'($urandom);
            else   mem_a[i] = 8'($urandom);
        end
    endtask

    // Builds the expected wire image for a frame accepted in cycle acc and
    // compares it, the IFG, the interrupt and the buffer reads with the log.
    task automatic check_frame(input bit b, input int acc, input int len,
                               input string nm, output int end_c);
        int          minf, body, wn, rd_n, en_n;
        logic [7:0]  w[$];
        logic [7:0]  by;
        logic [31:0] crc;
        samp_t       s;

        minf = b ? MIN_B : MIN_A;
        body = (len > minf) ? len : minf;
        for (int i = 0; i < PRE_LEN; i++) w.push_back(8'h55);
        w.push_back(8'hD5);
        crc = 32'hFFFF_FFFF;
        for (int i = 0; i < body; i++) begin
            by = (i < len) ? (b ? mem_b[i] : mem_a[i]) : 8'h00;
            w.push_back(by);
            crc = crc_tab[crc[7:0] ^ by] ^ (crc >> 8);
        end
        crc = ~crc;
        for (int k = 0; k < 4; k++) w.push_back(crc[8*k +: 8]);
        wn    = w.size();
        end_c = acc + 1 + wn + IFG;

        wait_until_cyc(end_c + 2);

        s = get(b, acc);
        check($sformatf("%s idle at accept {en,busy}", nm), {s.en, s.busy}, 2'b00);
        for (int j = 0; j < wn; j++) begin
            s = get(b, acc + 1 + j);
            check($sformatf("%s wire byte %0d {er,en,busy,irq,err,txd}", nm, j),
                  {s.er, s.en, s.busy, s.irq, s.err, s.txd},
                  {5'b01100, w[j]});
        end
        for (int k = 0; k < IFG; k++) begin
            s = get(b, acc + 1 + wn + k);
            check($sformatf("%s ifg %0d {er,en,busy,irq,txd}", nm, k),
                  {s.er, s.en, s.busy, s.irq, s.txd}, {4'b0010, 8'h00});
        end
        s = get(b, end_c);
        check($sformatf("%s irq cycle {en,busy,irq}", nm), {s.en, s.busy, s.irq}, 3'b001);
        s = get(b, end_c + 1);
        check($sformatf("%s irq single pulse", nm), {31'h0, s.irq}, 32'h0);

        for (int i = 0; i < len; i++) begin
            s = get(b, acc + PRE_LEN + i);
            check($sformatf("%s read for byte %0d {rd,addr}", nm, i),
                  {s.rd, s.addr}, {1'b1, ADDR_W'(i)});
        end
        rd_n = 0;
        en_n = 0;
        for (int c = acc; c <= end_c; c++) begin
            s = get(b, c);
            if (s.rd === 1'b1) rd_n++;
            if (s.en === 1'b1) en_n++;
        end
        check($sformatf("%s read count", nm), rd_n, len);
        check($sformatf("%s TX_EN cycles", nm), en_n, PRE_LEN + 1 + body + 4);
    endtask

    initial begin
        int    acc, acc2, end_c, irq_cyc, r, cnt;
        int    rlen;
        bit    rb;
        samp_t s;
        logic [31:0] c;
        logic [7:0]  check_str [9];
        logic [7:0]  fcs_ref [4];

        for (int n = 0; n < 256; n++) begin
            c = 32'(n);
            for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB8_8320) : (c >> 1);
            crc_tab[n] = c;
        end

        rst     = 1'b1;
        start_a = 1'b0;
        start_b = 1'b0;
        len_a   = '0;
        len_b   = '0;
        tick();
        tick();
        tick();
        check("reset A outputs", {er_a, en_a, txd_a, busy_a, irq_a, err_a, rd_a, addr_a}, '0);
        check("reset B outputs", {er_b, en_b, txd_b, busy_b, irq_b, err_b, rd_b, addr_b}, '0);
        rst = 1'b0;
        tick();

        // 60-byte incrementing frame: no padding, 72 TX_EN cycles.
        for (int i = 0; i < 60; i++) mem_a[i] = 8'(i);
        start_frame(1'b0, 60, acc);
        check_frame(1'b0, acc, 60, "A len60", end_c);

        // 14-byte frame padded with 46 zero bytes.
        fill_random(1'b0, 14);
        start_frame(1'b0, 14, acc);
        check_frame(1'b0, acc, 14, "A len14", end_c);

        // CRC check string on the unpadded instance.
        check_str = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        fcs_ref   = '{8'h26, 8'h39, 8'hF4, 8'hCB};
        for (int i = 0; i < 9; i++) mem_b[i] = check_str[i];
        start_frame(1'b1, 9, acc);
        check_frame(1'b1, acc, 9, "B check string", end_c);
        for (int k = 0; k < 4; k++) begin
            s = get(1'b1, acc + 1 + PRE_LEN + 1 + 9 + k);
            check($sformatf("B check string FCS byte %0d", k), {24'h0, s.txd}, {24'h0, fcs_ref[k]});
        end
        cnt = 0;
        for (int cc = acc; cc <= end_c; cc++) if (get(1'b1, cc).en === 1'b1) cnt++;
        check("B check string TX_EN cycles", cnt, 21);

        // Rejected lengths: 0 and MAX_LEN+1.
        for (int t = 0; t < 2; t++) begin
            rlen = (t == 0) ? 0 : MAX_LEN + 1;
            start_frame(1'b0, rlen, acc);
            wait_until_cyc(acc + 6);
            s = get(1'b0, acc + 1);
            check($sformatf("reject len %0d tx_err pulse", rlen), {31'h0, s.err}, 32'h1);
            s = get(1'b0, acc + 2);
            check($sformatf("reject len %0d tx_err one cycle", rlen), {31'h0, s.err}, 32'h0);
            cnt = 0;
            for (int cc = acc + 1; cc <= acc + 5; cc++) begin
                s = get(1'b0, cc);
                if (s.busy !== 1'b0 || s.en !== 1'b0) cnt++;
            end
            check($sformatf("reject len %0d busy/TX_EN stay low", rlen), cnt, 0);
        end

        // tx_start pulsed mid-DATA is ignored.
        fill_random(1'b0, 30);
        start_frame(1'b0, 30, acc);
        wait_until_cyc(acc + 20);
        start_a = 1'b1;
        len_a   = ADDR_W'(5);
        tick();
        start_a = 1'b0;
        check_frame(1'b0, acc, 30, "A mid-data start", end_c);
        cnt = 0;
        for (int cc = end_c + 1; cc <= end_c + 1; cc++) if (get(1'b0, cc).busy !== 1'b0) cnt++;
        wait_until_cyc(end_c + 5);
        for (int cc = end_c + 2; cc <= end_c + 4; cc++) if (get(1'b0, cc).busy !== 1'b0) cnt++;
        check("A mid-data start not queued", cnt, 0);

        // tx_start held through tx_irq: next frame starts right after the pulse.
        fill_random(1'b0, 25);
        start_a = 1'b1;
        len_a   = ADDR_W'(20);
        acc     = cyc;
        tick();
        len_a   = ADDR_W'(25);
        irq_cyc = -1;
        for (int i = 0; i < 500; i++) begin
            if (irq_a === 1'b1) begin
                irq_cyc = cyc;
                break;
            end
            tick();
        end
        tick();
        start_a = 1'b0;
        check("held start irq seen", {31'h0, irq_cyc >= 0}, 32'h1);
        check_frame(1'b0, acc, 20, "A held first", end_c);
        check("held start irq cycle", irq_cyc, end_c);
        check_frame(1'b0, irq_cyc, 25, "A held second", end_c);

        // Reset mid-DATA aborts on the same edge with no interrupt.
        fill_random(1'b0, 40);
        start_frame(1'b0, 40, acc);
        wait_until_cyc(acc + 20);
        rst = 1'b1;
        r   = cyc;
        tick();
        rst = 1'b0;
        wait_until_cyc(r + 150);
        s = get(1'b0, r);
        check("reset mid-data in frame {en,busy,rd}", {s.en, s.busy, s.rd}, 3'b111);
        s = get(1'b0, r + 1);
        check("reset mid-data abort {en,busy,rd,txd}", {s.en, s.busy, s.rd, s.txd}, '0);
        cnt = 0;
        for (int cc = r + 1; cc < r + 150; cc++) begin
            s = get(1'b0, cc);
            if (s.irq !== 1'b0 || s.en !== 1'b0) cnt++;
        end
        check("reset mid-data no irq / TX_EN", cnt, 0);

        // Length boundaries around the pad target and the maximum.
        for (int t = 0; t < 4; t++) begin
            case (t)
                0:       rlen = 1;
                1:       rlen = MIN_A - 1;
                2:       rlen = MIN_A + 1;
                default: rlen = MAX_LEN;
            endcase
            fill_random(1'b0, rlen);
            start_frame(1'b0, rlen, acc);
            check_frame(1'b0, acc, rlen, $sformatf("A len%0d", rlen), end_c);
        end

        // Random frames on both instances.
        for (int t = 0; t < 6; t++) begin
            rb   = (t % 3 == 2);
            rlen = int'($urandom_range(1, 120));
            fill_random(rb, rlen);
            start_frame(rb, rlen, acc2);
            check_frame(rb, acc2, rlen, $sformatf("%s random %0d len%0d", rb ? "B" : "A", t, rlen), end_c);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
